// File: rtl/axil_uart_lite_if.sv
// axil_uart_lite_if
// AXI4-Lite bus bundle for the UART slave: 13-bit byte address, 32-bit data.
// Ports (per channel):
//   AW: s_axi_awaddr, s_axi_awvalid, s_axi_awready
//   W : s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_wready
//   B : s_axi_bresp, s_axi_bvalid, s_axi_bready
//   AR: s_axi_araddr, s_axi_arvalid, s_axi_arready
//   R : s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rready
// Modports: slave (the UART), master (the bridge or a testbench).
interface axil_uart_lite_if;
    logic [12:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [12:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_uart_lite.sv
// axil_uart_lite
// AXI4-Lite UART slave: 8N1 framing, programmable baud divisor, TX/RX byte FIFOs.
// Ports:
//   clock    sole clock
//   resetn   asynchronous active-low reset
//   s_axi    AXI4-Lite slave bundle (axil_uart_lite_if.slave)
//   uart_RX  serial input, asynchronous to clock
//   uart_TX  serial output, idle high
//   irq      level interrupt, only when UART_LITE_IRQ_EN is defined
// Register map (addr[4:2]): 0x00 RXDATA, 0x04 TXDATA, 0x08 STATUS, 0x0C DIV,
// 0x10 IE (only when UART_LITE_IRQ_EN is defined). Everything else is SLVERR.
// Optional feature macro: UART_LITE_IRQ_EN.
module axil_uart_lite #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 433
) (
    input  logic            clock,
    input  logic            resetn,
    axil_uart_lite_if.slave s_axi,
    input  logic            uart_RX,
`ifdef UART_LITE_IRQ_EN
    output logic            irq,
`endif
    output logic            uart_TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);
`ifdef UART_LITE_IRQ_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;

    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q;
    logic        rxOvr_q, txOvf_q, frameErr_q;
    logic [7:0]  txMem [FIFO_DEPTH];
    logic [7:0]  rxMem [FIFO_DEPTH];
    logic [AW:0] txWr_q, txRd_q, rxWr_q, rxRd_q;
    txState_t    txState_q;
    rxState_t    rxState_q;
    logic [15:0] txCnt_q, txDiv_q, rxCnt_q, rxDiv_q;
    logic [2:0]  txBit_q, rxBit_q, rxSync_q;
    logic [7:0]  txShift_q, rxShift_q;
    logic        txOut_q;

    logic        wrAccept, wrHit, rdAccept, rdHit, statusClr;
    logic [2:0]  wrIdx, rdIdx;
    logic        txEmpty, txFull, rxEmpty, rxFull, txIdleEmpty;
    logic        txPushReq, txPush, txPop, rxPushReq, rxPush, rxPop, rxLine, frameEvt;
    logic [6:0]  status;
    logic        unusedBits;

    // Both AW and W must be present together; a pending B response blocks new writes.
    assign wrAccept = s_axi.s_axi_awvalid & s_axi.s_axi_wvalid & ~bvalid_q;
    assign wrIdx    = s_axi.s_axi_awaddr[4:2];
    assign wrHit    = (s_axi.s_axi_awaddr[12:5] == 8'd0) && (wrIdx <= LAST_IDX);
    assign rdAccept = s_axi.s_axi_arvalid & ~rvalid_q;
    assign rdIdx    = s_axi.s_axi_araddr[4:2];
    assign rdHit    = (s_axi.s_axi_araddr[12:5] == 8'd0) && (rdIdx <= LAST_IDX);

    assign s_axi.s_axi_awready = wrAccept;
    assign s_axi.s_axi_wready  = wrAccept;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = ~rvalid_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign uart_TX             = txOut_q;

    assign unusedBits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0],
                          s_axi.s_axi_wdata[31:16], s_axi.s_axi_wstrb[3:2]};

    // Full when the wrap bits differ and the index bits match.
    assign txEmpty = (txWr_q == txRd_q);
    assign rxEmpty = (rxWr_q == rxRd_q);
    assign txFull  = (txWr_q[AW] != txRd_q[AW]) && (txWr_q[AW-1:0] == txRd_q[AW-1:0]);
    assign rxFull  = (rxWr_q[AW] != rxRd_q[AW]) && (rxWr_q[AW-1:0] == rxRd_q[AW-1:0]);
    assign txIdleEmpty = txEmpty && (txState_q == TX_IDLE);

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign txPushReq = wrAccept & wrHit & (wrIdx == 3'd1) & s_axi.s_axi_wstrb[0];
    assign txPop     = ~txEmpty & ((txState_q == TX_IDLE) |
                                   ((txState_q == TX_STOP) & (txCnt_q == txDiv_q)));
    assign txPush    = txPushReq & (~txFull | txPop);
    assign rxLine    = rxSync_q[1];
    assign rxPushReq = (rxState_q == RX_STOP) & (rxCnt_q == rxDiv_q) & rxLine;
    assign frameEvt  = (rxState_q == RX_STOP) & (rxCnt_q == rxDiv_q) & ~rxLine;
    assign rxPop     = rdAccept & rdHit & (rdIdx == 3'd0) & ~rxEmpty;
    assign rxPush    = rxPushReq & (~rxFull | rxPop);
    assign statusClr = rdAccept & rdHit & (rdIdx == 3'd2);
    assign status    = {frameErr_q, txOvf_q, rxOvr_q, txFull, txIdleEmpty, rxFull, ~rxEmpty};

`ifdef UART_LITE_IRQ_EN
    logic [1:0] ie_q;
    logic       irq_q;
    assign irq = irq_q;

    // Interrupt enables and the registered interrupt level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ie_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (wrAccept && wrHit && wrIdx == 3'd4 && s_axi.s_axi_wstrb[0])
                ie_q <= s_axi.s_axi_wdata[1:0];
            irq_q <= (ie_q[0] & ~rxEmpty) | (ie_q[1] & txIdleEmpty);
        end
    end
`endif

    // Read data mux, captured into rdata_q at AR acceptance.
    always_comb begin
        rdata_d = 32'd0;
        rresp_d = rdHit ? 2'b00 : 2'b10;
        if (rdHit) begin
            case (rdIdx)
                3'd0:    rdata_d = rxEmpty ? 32'h8000_0000 : {24'd0, rxMem[rxRd_q[AW-1:0]]};
                3'd2:    rdata_d = {25'd0, status};
                3'd3:    rdata_d = {16'd0, div_q};
`ifdef UART_LITE_IRQ_EN
                3'd4:    rdata_d = {30'd0, ie_q};
`endif
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (txPush) txMem[txWr_q[AW-1:0]] <= s_axi.s_axi_wdata[7:0];
        if (rxPush) rxMem[rxWr_q[AW-1:0]] <= rxShift_q;
    end

    // Bus responses, DIV, FIFO pointers and sticky status. An event in the same
    // cycle as a STATUS read clear keeps the bit set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bvalid_q <= 1'b0;  bresp_q <= 2'b00;
            rvalid_q <= 1'b0;  rresp_q <= 2'b00;  rdata_q <= 32'd0;
            div_q    <= DIV_INIT;
            txWr_q   <= '0;  txRd_q <= '0;  rxWr_q <= '0;  rxRd_q <= '0;
            rxOvr_q  <= 1'b0;  txOvf_q <= 1'b0;  frameErr_q <= 1'b0;
        end else begin
            if (wrAccept) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wrHit ? 2'b00 : 2'b10;
            end else if (s_axi.s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (rdAccept) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (s_axi.s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
            if (wrAccept && wrHit && wrIdx == 3'd3) begin
                if (s_axi.s_axi_wstrb[0]) div_q[7:0]  <= s_axi.s_axi_wdata[7:0];
                if (s_axi.s_axi_wstrb[1]) div_q[15:8] <= s_axi.s_axi_wdata[15:8];
            end
            if (txPush) txWr_q <= txWr_q + 1'b1;
            if (txPop)  txRd_q <= txRd_q + 1'b1;
            if (rxPush) rxWr_q <= rxWr_q + 1'b1;
            if (rxPop)  rxRd_q <= rxRd_q + 1'b1;
            rxOvr_q    <= (rxOvr_q & ~statusClr) | (rxPushReq & ~rxPush);
            txOvf_q    <= (txOvf_q & ~statusClr) | (txPushReq & ~txPush);
            frameErr_q <= (frameErr_q & ~statusClr) | frameEvt;
        end
    end

    // TX FSM: each state lasts txDiv_q+1 cycles; the shifter presents the next
    // bit on every bit boundary and STOP chains straight into START if data waits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            txState_q <= TX_IDLE;  txCnt_q <= 16'd0;  txBit_q <= 3'd0;
            txShift_q <= 8'd0;     txDiv_q <= DIV_INIT; txOut_q <= 1'b1;
        end else begin
            txCnt_q <= txCnt_q + 16'd1;
            if (txPop) begin
                txState_q <= TX_START;
                txCnt_q   <= 16'd0;
                txDiv_q   <= div_q;
                txShift_q <= txMem[txRd_q[AW-1:0]];
                txOut_q   <= 1'b0;
            end else if (txCnt_q == txDiv_q) begin
                txCnt_q <= 16'd0;
                case (txState_q)
                    TX_START: begin
                        txState_q <= TX_DATA;
                        txBit_q   <= 3'd0;
                        txOut_q   <= txShift_q[0];
                        txShift_q <= txShift_q >> 1;
                    end
                    TX_DATA: begin
                        if (txBit_q == 3'd7) begin
                            txState_q <= TX_STOP;
                            txOut_q   <= 1'b1;
                        end else begin
                            txBit_q   <= txBit_q + 3'd1;
                            txOut_q   <= txShift_q[0];
                            txShift_q <= txShift_q >> 1;
                        end
                    end
                    TX_STOP: txState_q <= TX_IDLE;
                    default: txState_q <= TX_IDLE;
                endcase
            end
        end
    end

    // RX FSM: rxSync_q[1] is the synchronised line, rxSync_q[2] its previous
    // value for falling-edge detection. START samples half a bit in to reject glitches.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rxSync_q  <= 3'b111;   rxState_q <= RX_IDLE;  rxCnt_q <= 16'd0;
            rxBit_q   <= 3'd0;     rxShift_q <= 8'd0;     rxDiv_q <= DIV_INIT;
        end else begin
            rxSync_q <= {rxSync_q[1:0], uart_RX};
            rxCnt_q  <= rxCnt_q + 16'd1;
            case (rxState_q)
                RX_IDLE: if (rxSync_q[2] && !rxLine) begin
                    rxState_q <= RX_START;
                    rxCnt_q   <= 16'd0;
                    rxDiv_q   <= div_q;
                end
                RX_START: if (rxCnt_q == (rxDiv_q >> 1)) begin
                    rxState_q <= rxLine ? RX_IDLE : RX_DATA;
                    rxCnt_q   <= 16'd0;
                    rxBit_q   <= 3'd0;
                end
                RX_DATA: if (rxCnt_q == rxDiv_q) begin
                    rxCnt_q   <= 16'd0;
                    rxShift_q <= {rxLine, rxShift_q[7:1]};
                    rxBit_q   <= rxBit_q + 3'd1;
                    if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
                end
                RX_STOP: if (rxCnt_q == rxDiv_q) begin
                    rxCnt_q   <= 16'd0;
                    rxState_q <= rxLine ? RX_IDLE : RX_WAIT;
                end
                RX_WAIT: if (rxLine) rxState_q <= RX_IDLE;
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_uart_lite.sv
// tb_axil_uart_lite
// Directed testbench for axil_uart_lite (default build, UART_LITE_IRQ_EN undefined).
// Expected bus responses, serial bits and received bytes are queued when the
// stimulus is issued and popped when the DUT produces the matching output.
module tb_axil_uart_lite;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic uart_RX = 1'b1;
    logic uart_TX;
    int   checks   = 0;
    int   failures = 0;

    logic [33:0] rdExpQ[$];
    logic [1:0]  bExpQ[$];
    logic [7:0]  rxByteQ[$];
    logic        txBitQ[$];

    axil_uart_lite_if bus();

    axil_uart_lite #(.FIFO_DEPTH(16), .DIV_RESET(433)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .s_axi   (bus),
        .uart_RX (uart_RX),
        .uart_TX (uart_TX)
    );

    // 100 MHz-style free-running clock.
    always #5 clock = ~clock;

    // Hard stop in case a wait somewhere escapes its bound.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // An expired wait bound counts as a failed comparison.
    task automatic timeoutFail(input string tag);
        checks++;
        failures++;
        $display("[TB] FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // One AXI-Lite write; the expected response is queued before the handshake.
    task automatic axiWrite(input logic [12:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] expResp,
                            input string tag);
        bit done;
        logic [1:0] exp;
        bExpQ.push_back(expResp);
        bus.s_axi_awaddr  = addr;
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (bus.s_axi_awready && bus.s_axi_wready) done = 1'b1;
        end
        if (done) @(posedge clock);
        #1;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        if (!done) begin
            timeoutFail({tag, " aw/w accept"});
            exp = bExpQ.pop_front();
        end else begin
            bus.s_axi_bready = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clock);
                if (bus.s_axi_bvalid) done = 1'b1;
            end
            exp = bExpQ.pop_front();
            if (done) begin
                checkOutput({tag, " bresp"}, {30'd0, bus.s_axi_bresp}, {30'd0, exp});
                @(posedge clock);
                #1;
            end else begin
                timeoutFail({tag, " bvalid"});
            end
            bus.s_axi_bready = 1'b0;
        end
    endtask

    // One AXI-Lite read; expected {rresp, rdata} is queued before the handshake.
    task automatic axiRead(input logic [12:0] addr, input logic [31:0] expData,
                           input logic [1:0] expResp, input string tag);
        bit done;
        logic [33:0] exp;
        rdExpQ.push_back({expResp, expData});
        bus.s_axi_araddr  = addr;
        bus.s_axi_arvalid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (bus.s_axi_arready) done = 1'b1;
        end
        if (done) @(posedge clock);
        #1;
        bus.s_axi_arvalid = 1'b0;
        if (!done) begin
            timeoutFail({tag, " ar accept"});
            exp = rdExpQ.pop_front();
        end else begin
            bus.s_axi_rready = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clock);
                if (bus.s_axi_rvalid) done = 1'b1;
            end
            exp = rdExpQ.pop_front();
            if (done) begin
                checkOutput({tag, " rdata"}, bus.s_axi_rdata, exp[31:0]);
                checkOutput({tag, " rresp"}, {30'd0, bus.s_axi_rresp}, {30'd0, exp[33:32]});
                @(posedge clock);
                #1;
            end else begin
                timeoutFail({tag, " rvalid"});
            end
            bus.s_axi_rready = 1'b0;
        end
    endtask

    // Drives one 8N1 frame on uart_RX, each bit held div+1 clocks.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int div);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_RX = bits[b];
            repeat (div + 1) @(posedge clock);
            #1;
        end
        uart_RX = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        bit          seen;
        logic        expBit;
        logic [7:0]  b;
        logic [7:0]  txByte;

        bus.s_axi_awaddr  = '0;  bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;  bus.s_axi_wstrb   = '0;  bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_araddr  = '0;  bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;

        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // Reset state.
        @(negedge clock);
        checkOutput("reset uart_TX", {31'd0, uart_TX}, 32'd1);
        checkOutput("reset bvalid", {31'd0, bus.s_axi_bvalid}, 32'd0);
        checkOutput("reset rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
        checkOutput("reset rdata", bus.s_axi_rdata, 32'd0);
        @(posedge clock);
        #1;
        axiRead(13'h08, 32'h0000_0004, 2'b00, "reset STATUS");
        axiRead(13'h0C, 32'd433, 2'b00, "reset DIV");

        // TX frame at DIV=3: 4 clocks per bit, 0x55 sent LSB first.
        axiWrite(13'h0C, 32'd3, 4'hF, 2'b00, "DIV=3");
        txByte = 8'h55;
        txBitQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) txBitQ.push_back(txByte[i]);
        txBitQ.push_back(1'b1);
        axiWrite(13'h04, {24'd0, txByte}, 4'h1, 2'b00, "TXDATA 0x55");
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (uart_TX === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            timeoutFail("TX start bit");
            txBitQ.delete();
        end else begin
            for (int bitNo = 0; bitNo < 10; bitNo++) begin
                expBit = txBitQ.pop_front();
                for (int c = 0; c < 4; c++) begin
                    if (bitNo != 0 || c != 0) @(negedge clock);
                    checkOutput($sformatf("TX bit %0d cycle %0d", bitNo, c),
                                {31'd0, uart_TX}, {31'd0, expBit});
                end
            end
            @(negedge clock);
            checkOutput("TX idle after stop", {31'd0, uart_TX}, 32'd1);
        end
        @(posedge clock);
        #1;
        axiRead(13'h08, 32'h0000_0004, 2'b00, "STATUS after TX frame");

        // DIV byte strobes: only byte 1 written.
        axiWrite(13'h0C, 32'h1234_ABCD, 4'b0010, 2'b00, "DIV strobe byte1");
        axiRead(13'h0C, 32'h0000_AB03, 2'b00, "DIV after strobe");
        axiWrite(13'h0C, 32'd7, 4'hF, 2'b00, "DIV=7");

        // Single RX frame.
        applyStimulus(8'hA3, 1'b1, 7);
        axiRead(13'h08, 32'h0000_0005, 2'b00, "STATUS after RX 0xA3");
        axiRead(13'h00, 32'h0000_00A3, 2'b00, "RXDATA 0xA3");
        axiRead(13'h00, 32'h8000_0000, 2'b00, "RXDATA empty");

        // Park TX in a very long frame so tx_empty reads 0 for the rest of the run;
        // DIV is then restored for RX, which latches it per frame.
        axiWrite(13'h0C, 32'h0000_FFFF, 4'hF, 2'b00, "DIV=FFFF");
        axiWrite(13'h04, 32'h0000_0000, 4'h1, 2'b00, "TXDATA long frame");
        repeat (3) @(posedge clock);
        #1;
        axiWrite(13'h0C, 32'd7, 4'hF, 2'b00, "DIV=7 again");
        axiRead(13'h08, 32'h0000_0000, 2'b00, "STATUS TX busy");

        // 17 frames into a 16-deep FIFO: the last is dropped, rx_ovr sets.
        for (int i = 0; i < 17; i++) begin
            b = 8'(8'h31 + i * 7);
            if (i < 16) rxByteQ.push_back(b);
            applyStimulus(b, 1'b1, 7);
        end
        axiRead(13'h08, 32'h0000_0013, 2'b00, "STATUS overflow");
        axiRead(13'h08, 32'h0000_0003, 2'b00, "STATUS after clear");
        for (int i = 0; i < 16; i++) begin
            b = rxByteQ.pop_front();
            axiRead(13'h00, {24'd0, b}, 2'b00, $sformatf("RXDATA fifo %0d", i));
        end
        axiRead(13'h00, 32'h8000_0000, 2'b00, "RXDATA drained");
        axiRead(13'h08, 32'h0000_0000, 2'b00, "STATUS drained");

        // Framing error: byte discarded, frame_err set then cleared by read.
        applyStimulus(8'h5A, 1'b0, 7);
        repeat (4) @(posedge clock);
        #1;
        axiRead(13'h08, 32'h0000_0040, 2'b00, "STATUS frame_err");
        axiRead(13'h00, 32'h8000_0000, 2'b00, "RXDATA after frame_err");
        axiRead(13'h08, 32'h0000_0000, 2'b00, "STATUS frame_err cleared");

        // Short low glitch is rejected at the half-bit check.
        uart_RX = 1'b0;
        repeat (2) @(posedge clock);
        #1 uart_RX = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        axiRead(13'h08, 32'h0000_0000, 2'b00, "STATUS after glitch");
        axiRead(13'h00, 32'h8000_0000, 2'b00, "RXDATA after glitch");

        // Decode errors and write-only / read-only registers.
        axiRead(13'h14, 32'h0000_0000, 2'b10, "read 0x14");
        axiWrite(13'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, "write 0x1C");
        axiRead(13'h10, 32'h0000_0000, 2'b10, "read 0x10 no IE");
        axiRead(13'h28, 32'h0000_0000, 2'b10, "read high addr");
        axiRead(13'h04, 32'h0000_0000, 2'b00, "read TXDATA");
        axiWrite(13'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, "write STATUS");
        axiRead(13'h0C, 32'h0000_0007, 2'b00, "DIV unchanged");

        // B backpressure: a second write stays blocked while bvalid waits.
        bExpQ.push_back(2'b00);
        bus.s_axi_awaddr  = 13'h08;
        bus.s_axi_wdata   = 32'd0;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.s_axi_awready) seen = 1'b1;
        end
        if (!seen) begin
            timeoutFail("bready hold accept");
        end else begin
            @(posedge clock);
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                checkOutput($sformatf("hold %0d bvalid", i), {31'd0, bus.s_axi_bvalid}, 32'd1);
                checkOutput($sformatf("hold %0d awready", i), {31'd0, bus.s_axi_awready}, 32'd0);
            end
        end
        @(posedge clock);
        #1;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b1;
        @(negedge clock);
        checkOutput("hold bresp", {30'd0, bus.s_axi_bresp}, {30'd0, bExpQ.pop_front()});
        @(posedge clock);
        #1 bus.s_axi_bready = 1'b0;
        @(negedge clock);
        checkOutput("hold bvalid released", {31'd0, bus.s_axi_bvalid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_uart_lite.md
Name: axil_uart_lite

Overview:
- Native AXI4-Lite UART slave: 32-bit data, 13-bit byte address, 8N1 framing, programmable baud divisor, TX and RX byte FIFOs.
- Sits directly downstream of the AXI4-to-AXI4-Lite bridge in the peripheral subsystem.
- Drop-in replacement for the vendor 16550 core: same lite port set, minus the modem pins.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2..256.
- DIV_RESET, 433, reset value of DIV; bit period = DIV+1 clocks (115200 baud at 50 MHz).

Ports:
- clock  input  1  sole clock
- resetn  input  1  asynchronous active-low reset
- s_axi_awaddr  input  13  write address
- s_axi_awvalid/s_axi_awready  input/output  1  AW handshake
- s_axi_wdata  input  32  write data
- s_axi_wstrb  input  4  byte strobes
- s_axi_wvalid/s_axi_wready  input/output  1  W handshake
- s_axi_bresp  output  2  write response
- s_axi_bvalid/s_axi_bready  output/input  1  B handshake
- s_axi_araddr  input  13  read address
- s_axi_arvalid/s_axi_arready  input/output  1  AR handshake
- s_axi_rdata  output  32  read data
- s_axi_rresp  output  2  read response
- s_axi_rvalid/s_axi_rready  output/input  1  R handshake
- uart_RX  input  1  serial in, asynchronous
- uart_TX  output  1  serial out, idle high

Behaviour:
- Reset values: all ready/valid outputs 0, bresp/rresp/rdata 0, uart_TX 1, FIFOs empty, sticky bits 0, DIV=DIV_RESET, both FSMs IDLE.
- Reset mid-frame aborts the frame immediately; uart_TX returns high asynchronously.

Write channel:
- awready=wready=1 in the same cycle only when awvalid&wvalid&!bvalid. AW alone or W alone is never accepted.
- bvalid asserts the cycle after acceptance and holds until bready.

Read channel:
- arready=!rvalid. rvalid asserts the cycle after acceptance; rdata/rresp are registered and stable until rready.

Address decode (addr[4:2]):
- 0x00 RXDATA RO: [7:0] byte, [31] empty.
  - Empty: returns 0x8000_0000, no pop.
  - Otherwise the pop occurs at AR acceptance.
- 0x04 TXDATA WO: wstrb[0]=1 pushes wdata[7:0].
  - FIFO full: byte dropped and tx_ovf set.
  - Reads return 0.
- 0x08 STATUS RO: [0] rx_nonempty, [1] rx_full, [2] tx_empty (FIFO empty and TX idle), [3] tx_full, [4] rx_ovr, [5] tx_ovf, [6] frame_err.
  - Read clears [6:4] at AR acceptance.
  - An event in the same cycle as the clear wins (bit stays 1).
- 0x0C DIV RW [15:0], upper bits read 0. Byte strobes honoured.
- Writes to RO registers are ignored with OKAY.
- Any other address, or addr[12:5]!=0: SLVERR (2'b10), rdata 0, no side effects.

TX FSM:
- States IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
- Each state lasts DIV+1 cycles; a bit counter counts 0..7.
- Leaves IDLE the cycle after the FIFO becomes non-empty; pops at START entry.
- Back-to-back frames: STOP -> START with no idle gap.

RX FSM:
- uart_RX passes through a 2-flop synchroniser.
- IDLE: a detected 1->0 edge goes to START.
- START: wait DIV>>1 cycles, then resample.
  - High: glitch, back to IDLE.
  - Low: go to DATA.
- DATA: sample every DIV+1 cycles, 8 bits LSB first, then STOP.
- STOP: sample the stop bit.
  - 0: frame_err set, byte discarded; wait for line high, then IDLE.
  - 1: push the byte.
- Push into a full FIFO drops the byte and sets rx_ovr.
- A push and a pop in the same cycle on a full FIFO both succeed.

DIV and FIFOs:
- DIV is latched separately by each FSM at frame start; a DIV write mid-frame affects only the next frame.
- DIV<7 is unsupported (RX mid-bit accuracy).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest are equal.

Optional Feature:
- Macro: UART_LITE_IRQ_EN.
- With it defined:
  - Adds output irq (1 bit, registered, reset 0).
  - Adds IE register at 0x10 RW: [0] rx_ie, [1] tx_ie.
  - irq = (rx_ie & rx_nonempty) | (tx_ie & tx_empty).
- Without it: no irq port; 0x10 returns SLVERR.

Test Plan:
- Reset, then read 0x08 -> rdata 0x0000_0004; read 0x0C -> 433; uart_TX=1.
- DIV=3, write 0x55 to 0x04 -> uart_TX: 4 cycles low, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 cycles high; STATUS[2] returns to 1 after 40 cycles.
- DIV=7, drive 0xA3 8N1 on uart_RX -> STATUS[0]=1; read 0x00 -> 0x0000_00A3; second read -> 0x8000_0000.
- Send 17 frames with FIFO_DEPTH=16, no reads -> STATUS=0x13 (rx_nonempty, rx_full, rx_ovr); second STATUS read -> 0x03; first 16 bytes intact.
- Frame with stop bit 0 -> STATUS[6]=1, FIFO unchanged.
- 2-cycle low glitch on uart_RX -> no push.
- Read 0x14, write 0x1C -> rresp=2'b10 with rdata 0; bresp=2'b10.
- Hold bready low 5 cycles -> bvalid stays high and awready stays low throughout.
